// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: serves one load/store
// per request after LATENCY cycles and stalls the pipeline meanwhile.
module data_mem_responder #(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic            r_rd;
    logic            r_wr;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_acc;
    logic            w_commit;
    logic            w_is_rd;
    logic            w_is_wr;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_wdata;
    logic            w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_unused = ^addr[31:AW+2];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        mem_stall  = 1'b0;
        w_acc      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                mem_stall = w_req;
                if (w_req) begin
                    w_acc      = 1'b1;
                    w_cnt_next = LAT_M1;
                    w_next     = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall  = 1'b1;
                w_cnt_next = 4'(r_cnt - 4'd1);
                if (r_cnt == 4'd1)
                    w_next = S_RESP;
            end
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With LATENCY==1 the commit happens on the accepting edge, so take
    // the live request instead of the not-yet-latched copy.
    assign w_is_rd  = w_acc ? mem_read   : r_rd;
    assign w_is_wr  = w_acc ? mem_write  : r_wr;
    assign w_idx    = w_acc ? addr[AW+1:2] : r_idx;
    assign w_wdata  = w_acc ? write_data : r_wdata;
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            read_data <= 32'd0;
            align_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_acc) begin
                r_rd    <= mem_read;
                r_wr    <= mem_write;
                r_idx   <= addr[AW+1:2];
                r_wdata <= write_data;
                if (addr[1:0] != 2'b00)
                    align_err <= 1'b1;
            end
            if (w_commit) begin
                if (w_is_wr && w_is_rd)
                    read_data <= 32'd0;
                else if (!w_is_wr)
                    read_data <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_commit && w_is_wr)
            r_mem[w_idx] <= w_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=3 and LATENCY=1 instances checked
// cycle by cycle against a word-array reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] ad    [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        aerr  [2];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mdl    [2][1024];
    logic [31:0] exp_rd [2];
    logic        exp_ae [2];
    int          lat    [2];

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(3), .DEPTH_WORDS(1024), .AW(10)) dut0 (
        .clk(clk), .rst(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .addr(ad[0]), .write_data(wd[0]), .read_data(rdata[0]),
        .mem_stall(stall[0]), .align_err(aerr[0])
    );

    data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024), .AW(10)) dut1 (
        .clk(clk), .rst(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .addr(ad[1]), .write_data(wd[1]), .read_data(rdata[1]),
        .mem_stall(stall[1]), .align_err(aerr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input int w, input string tag, input logic st);
        chk({tag, "_stall"}, {31'd0, stall[w]}, {31'd0, st});
        chk({tag, "_rdata"}, rdata[w], exp_rd[w]);
        chk({tag, "_aerr"}, {31'd0, aerr[w]}, {31'd0, exp_ae[w]});
    endtask

    // One complete access starting in an IDLE cycle; inputs are scrambled
    // while the access is in flight since the DUT must ignore them.
    task automatic acc(input int w, input bit r, input bit wv,
                       input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = int'((a >> 2) & 32'h3FF);
        rd[w] = r;
        wr[w] = wv;
        ad[w] = a;
        wd[w] = d;
        @(negedge clk);
        chk_outs(w, "req", 1'b1);
        step();
        if (a[1:0] != 2'b00)
            exp_ae[w] = 1'b1;
        for (int k = 1; k < lat[w]; k++) begin
            rd[w] = 1'($urandom);
            wr[w] = 1'($urandom);
            ad[w] = $urandom;
            wd[w] = $urandom;
            @(negedge clk);
            chk_outs(w, "wait", 1'b1);
            step();
        end
        if (wv)
            mdl[w][idx] = d;
        if (r && wv)
            exp_rd[w] = 32'd0;
        else if (r)
            exp_rd[w] = mdl[w][idx];
        rd[w] = 1'b0;
        wr[w] = 1'b0;
        @(negedge clk);
        chk_outs(w, "resp", 1'b0);
        step();
    endtask

    task automatic rnd_acc(input int w);
        logic [31:0] a;
        int op;
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
        if ($urandom_range(0, 3) == 0)
            a[1:0] = 2'($urandom_range(1, 3));
        op = $urandom_range(0, 4);
        acc(w, op != 1, op >= 1 && op != 4 ? 1'b1 : 1'b0, a, $urandom);
    endtask

    initial begin
        lat[0] = 3;
        lat[1] = 1;
        for (int w = 0; w < 2; w++) begin
            rst_n[w]  = 1'b0;
            rd[w]     = 1'b0;
            wr[w]     = 1'b0;
            ad[w]     = 32'd0;
            wd[w]     = 32'd0;
            exp_rd[w] = 32'd0;
            exp_ae[w] = 1'b0;
        end
        step();
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();
        @(negedge clk);
        chk_outs(0, "rst0", 1'b0);
        chk_outs(1, "rst1", 1'b0);
        step();

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++)
                acc(w, 1'b0, 1'b1, 32'(i) << 2, $urandom);

        acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("ld10", rdata[0], 32'hDEADBEEF);

        acc(0, 1'b0, 1'b1, 32'h14, 32'h12345678);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0);
        acc(0, 1'b1, 1'b0, 32'h14, 32'h0);
        chk("ld14", rdata[0], 32'h12345678);

        acc(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        rd[0] = 1'b0;
        wr[0] = 1'b1;
        ad[0] = 32'h20;
        wd[0] = 32'hAAAA5555;
        @(negedge clk);
        chk_outs(0, "abort_req", 1'b1);
        step();
        wr[0]    = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk_outs(0, "abort_wait", 1'b1);
        step();
        rst_n[0]  = 1'b1;
        exp_rd[0] = 32'd0;
        exp_ae[0] = 1'b0;
        @(negedge clk);
        chk_outs(0, "abort_idle", 1'b0);
        step();
        acc(0, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("ld20", rdata[0], 32'hCAFEF00D);

        acc(0, 1'b1, 1'b0, 32'h13, 32'h0);
        chk("ld13", rdata[0], 32'hDEADBEEF);
        chk("ae13", {31'd0, aerr[0]}, 32'd1);
        acc(0, 1'b0, 1'b1, 32'h24, 32'h1);
        chk("ae_sticky", {31'd0, aerr[0]}, 32'd1);
        acc(0, 1'b1, 1'b0, 32'h1010, 32'h0);
        chk("ld1010", rdata[0], 32'hDEADBEEF);

        acc(0, 1'b1, 1'b1, 32'h40, 32'h55);
        acc(0, 1'b1, 1'b0, 32'h40, 32'h0);
        chk("ld40", rdata[0], 32'h55);
        acc(1, 1'b1, 1'b1, 32'h40, 32'h55);
        acc(1, 1'b1, 1'b0, 32'h40, 32'h0);

        for (int i = 0; i < 80; i++)
            rnd_acc(0);
        for (int i = 0; i < 80; i++)
            rnd_acc(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
